// File: rtl/mul_operand_dispatcher.sv
// mul_operand_dispatcher
// Issue stage that feeds a fixed-latency, non-stallable multiplier.
// It queues operand pairs, issues them when a result slot is guaranteed,
// follows each issue through a latency pipe, and buffers the products
// until downstream accepts them. Results leave in issue order.

module mul_operand_dispatcher #(
   parameter int N         = 16,
   parameter int OP_DEPTH  = 4,
   parameter int RES_DEPTH = 4,
   parameter int LATENCY   = 3,
   parameter int ISSUE_GAP = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           mul_load,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [2*N:0]   mul_z,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N:0]   out_z,
   output logic           busy
);

   localparam int ZW       = 2 * N + 1;
   localparam int OP_AW    = $clog2(OP_DEPTH);
   localparam int OP_CW    = OP_AW + 1;
   localparam int RES_AW   = $clog2(RES_DEPTH);
   localparam int RES_CW   = RES_AW + 1;
   localparam int CREDIT_W = RES_CW + 1;
   localparam int GAP_W    = $clog2(ISSUE_GAP) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Operand FIFO storage and bookkeeping
   logic [N-1:0]      r_opMemA [OP_DEPTH];
   logic [N-1:0]      r_opMemB [OP_DEPTH];
   logic [OP_AW-1:0]  r_opWr;
   logic [OP_AW-1:0]  r_opRd;
   logic [OP_CW-1:0]  r_opCount;

   // Issue side registers
   logic              r_mulLoad;
   logic [N-1:0]      r_mulA;
   logic [N-1:0]      r_mulB;
   logic [GAP_W-1:0]  r_gapCnt;

   // Latency tracking
   logic [LATENCY-1:0] r_vpipe;
   logic [RES_CW-1:0]  r_inflight;

   // Result FIFO storage and bookkeeping
   logic [ZW-1:0]      r_resMem [RES_DEPTH];
   logic [RES_AW-1:0]  r_resWr;
   logic [RES_AW-1:0]  r_resRd;
   logic [RES_CW-1:0]  r_resCount;

   // Control FSM
   state_t             r_state;
   logic               r_busy;

   // Combinational decisions
   logic               w_push;
   logic               w_issue;
   logic               w_capture;
   logic               w_resPop;
   logic               w_creditOk;
   logic               w_opNotEmpty;
   logic               w_pending;
   logic [CREDIT_W-1:0] w_creditUsed;

   // The ready flag depends only on the stored count, so a full FIFO stays
   // not-ready for the whole cycle even if the head is issued in that cycle.
   assign in_ready     = (r_opCount != OP_CW'(OP_DEPTH));
   assign w_push       = in_valid && in_ready;
   assign w_opNotEmpty = (r_opCount != '0);

   // A slot is reserved for every in-flight product, so the multiplier can
   // never deliver a result the result FIFO has no room for.
   assign w_creditUsed = CREDIT_W'(r_inflight) + CREDIT_W'(r_resCount);
   assign w_creditOk   = (w_creditUsed < CREDIT_W'(RES_DEPTH));
   assign w_issue      = w_opNotEmpty && (r_gapCnt == '0) && w_creditOk;

   assign w_capture    = r_vpipe[LATENCY-1];
   assign w_resPop     = out_valid && out_ready;
   assign w_pending    = (r_inflight != '0) || (r_resCount != '0);

   assign mul_load     = r_mulLoad;
   assign mul_a        = r_mulA;
   assign mul_b        = r_mulB;
   assign out_valid    = (r_resCount != '0);
   assign out_z        = r_resMem[r_resRd];
   assign busy         = r_busy;

   // Operand FIFO: write on an accepted push, advance the head on issue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < OP_DEPTH; i++) begin
            r_opMemA[i] <= '0;
            r_opMemB[i] <= '0;
         end
         r_opWr    <= '0;
         r_opRd    <= '0;
         r_opCount <= '0;
      end else begin
         if (w_push) begin
            r_opMemA[r_opWr] <= in_a;
            r_opMemB[r_opWr] <= in_b;
            r_opWr           <= r_opWr + OP_AW'(1);
         end
         if (w_issue) begin
            r_opRd <= r_opRd + OP_AW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_opCount <= r_opCount + OP_CW'(1);
            2'b01:   r_opCount <= r_opCount - OP_CW'(1);
            default: r_opCount <= r_opCount;
         endcase
      end
   end

   // Issue register: one-cycle load pulse, operands held until the next issue, spacing counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mulLoad <= 1'b0;
         r_mulA    <= '0;
         r_mulB    <= '0;
         r_gapCnt  <= '0;
      end else begin
         r_mulLoad <= w_issue;
         if (w_issue) begin
            r_mulA   <= r_opMemA[r_opRd];
            r_mulB   <= r_opMemB[r_opRd];
            r_gapCnt <= GAP_W'(ISSUE_GAP - 1);
         end else if (r_gapCnt != '0) begin
            r_gapCnt <= r_gapCnt - GAP_W'(1);
         end
      end
   end

   // Valid pipe mirrors the multiplier latency; inflight counts issued but not yet captured products
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vpipe    <= '0;
         r_inflight <= '0;
      end else begin
         r_vpipe[0] <= r_mulLoad;
         for (int i = 1; i < LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
         case ({w_issue, w_capture})
            2'b10:   r_inflight <= r_inflight + RES_CW'(1);
            2'b01:   r_inflight <= r_inflight - RES_CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Result FIFO: capture the multiplier output when its pipe slot matures, pop on output handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RES_DEPTH; i++) begin
            r_resMem[i] <= '0;
         end
         r_resWr    <= '0;
         r_resRd    <= '0;
         r_resCount <= '0;
      end else begin
         if (w_capture) begin
            r_resMem[r_resWr] <= mul_z;
            r_resWr           <= r_resWr + RES_AW'(1);
         end
         if (w_resPop) begin
            r_resRd <= r_resRd + RES_AW'(1);
         end
         case ({w_capture, w_resPop})
            2'b10:   r_resCount <= r_resCount + RES_CW'(1);
            2'b01:   r_resCount <= r_resCount - RES_CW'(1);
            default: r_resCount <= r_resCount;
         endcase
      end
   end

   // Activity FSM: RUN while operands wait, DRAIN while only results remain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_opNotEmpty) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               if (!w_opNotEmpty) begin
                  if (w_pending) begin
                     r_state <= DRAIN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (w_opNotEmpty) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end else if (!w_pending) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
